dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Two-master arbiter sharing one data-bus slave port, which feeds the address-decoding bus mux (RAM/IO/UART0/Timer/Timer1).
- M0 is the Ibex data port; M1 is a secondary master (DMA/debug loader).
- Uses the Ibex req/gnt/rvalid protocol with round-robin arbitration.
- Tracks outstanding transactions in an owner FIFO so each response returns to the master that issued it.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte enables = DW/8).
- MAX_OUT, 2, maximum outstanding (granted, not yet responded) transactions; owner FIFO depth, power of 2, >= 1.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  master request, held until granted.
- m0_we, m1_we  in  1  write enable.
- m0_be, m1_be  in  DW/8  byte enables.
- m0_addr, m1_addr  in  AW  address.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_gnt, m1_gnt  out  1  address-phase grant.
- m0_rvalid, m1_rvalid  out  1  response valid.
- m0_err, m1_err  out  1  response error.
- m0_rdata, m1_rdata  out  DW  read data.
- s_req, s_we, s_be, s_addr, s_wdata  out  1/1/DW/8/AW/DW  to slave (bus mux).
- s_gnt, s_rvalid, s_err  in  1  from slave.
- s_rdata  in  DW  from slave.
- busy  out  1  owner FIFO non-empty.
- proto_err  out  1  sticky: rvalid received with no outstanding transaction.

Behaviour:
- Reset (sync, Rst=1 at posedge):
  - owner FIFO emptied; rr_ptr=0 (M0 preferred); lock=0; proto_err=0.
  - All outputs 0 while FIFO empty and no req.
  - Reset mid-transaction discards pending owners; responses arriving later count as stray.
- Selection (combinational, from registered state):
  - If lock=1, sel = locked_id.
  - Else if exactly one mN_req=1, sel = that master.
  - Else if both requesting, sel = rr_ptr.
  - Else no selection.
- Slave drive:
  - s_req = selected req & ~full.
  - s_we/s_be/s_addr/s_wdata = selected master's fields.
  - All s_* = 0 when nothing is selected.
- Grant: mN_gnt = s_gnt & s_req & (sel==N). Zero added latency; gnt is combinational from s_gnt.
- Lock (registered):
  - Set to sel when s_req=1 and s_gnt=0.
  - Cleared on the s_req&s_gnt handshake.
  - Guarantees the address phase is never switched away from a master that is waiting; the Ibex rule that req is not withdrawn before gnt is preserved.
- Round robin: on each s_req&s_gnt, rr_ptr <= ~sel; otherwise rr_ptr is held.
- Owner FIFO (count 0..MAX_OUT):
  - Push sel on s_req&s_gnt; pop head on s_rvalid.
  - Push and pop in the same cycle: count unchanged, head advances.
  - full = (count==MAX_OUT). When full, s_req is forced 0 and no gnt is issued, even if s_rvalid pops that cycle (takes effect next cycle).
- Response routing:
  - mN_rvalid = s_rvalid & ~empty & (head==N).
  - mN_err = s_err & mN_rvalid.
  - mN_rdata = s_rdata when head==N & ~empty, else 0.
  - Minimum request-to-response latency equals the slave's (1 cycle for RAM); the arbiter adds no cycles.
- Stray response: s_rvalid=1 with FIFO empty is not forwarded to either master; proto_err <= 1 until Rst.
- Response ordering: strictly in grant order; the slave must respond in order.
- busy = ~empty.

Test Plan:
- Single master:
  - Stimulus: M0 read addr 0x0000_0100; slave gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF.
  - Response: m0_gnt in cycle 0, m0_rvalid/m0_rdata=0xDEADBEEF in cycle 1, m1_rvalid=0, busy high for 1 cycle.
- Contention:
  - Stimulus: M0 and M1 both request continuously from reset, slave always grants.
  - Response: grants alternate M0, M1, M0, M1; responses routed in the same order.
- Lock:
  - Stimulus: M1 alone requests with s_gnt=0 for 3 cycles; M0 raises req in cycle 1.
  - Response: s_addr stays on M1 for all 3 cycles; M1 granted when s_gnt=1; M0 granted the following cycle.
- Full back-pressure (MAX_OUT=2):
  - Stimulus: two grants issued with no rvalid.
  - Response: third req sees s_req=0 and no gnt; after one s_rvalid, s_req reasserts the next cycle.
- Error and stray:
  - Stimulus: s_err=1 with rvalid for an M1 write.
  - Response: m1_err=1, m0_err=0.
  - Stimulus: then rvalid with FIFO empty.
  - Response: no mN_rvalid; proto_err=1 stays until Rst.
- Reset mid-operation:
  - Stimulus: Rst pulsed with 2 outstanding.
  - Response: busy=0, rr_ptr=M0; a subsequent late rvalid sets proto_err.

Source files
------------

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin two-master arbiter onto one Ibex-protocol data-bus slave port,
// with an owner FIFO that routes each in-order response back to the master that issued it.
module dbus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_OUT = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic            m0_err,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic            m1_err,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_req,
  output logic            s_we,
  output logic [DW/8-1:0] s_be,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_gnt,
  input  logic            s_rvalid,
  input  logic            s_err,
  input  logic [DW-1:0]   s_rdata,
  output logic            busy,
  output logic            proto_err
);
  localparam int PW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [MAX_OUT-1:0] owner;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic lock, locked_id, rr_ptr;
  logic any, sel, sel_req, full, empty, head, hs, pop;
  always_comb begin
    any = lock | m0_req | m1_req;
    sel = lock ? locked_id : (m0_req & m1_req) ? rr_ptr : m1_req;
    sel_req = sel ? m1_req : m0_req;
    full = cnt == CW'(MAX_OUT);
    empty = cnt == '0;
    head = owner[rp];
    s_req = sel_req & ~full;
    s_we = any & (sel ? m1_we : m0_we);
    s_be = any ? (sel ? m1_be : m0_be) : '0;
    s_addr = any ? (sel ? m1_addr : m0_addr) : '0;
    s_wdata = any ? (sel ? m1_wdata : m0_wdata) : '0;
    hs = s_req & s_gnt;
    pop = s_rvalid & ~empty;
    m0_gnt = hs & ~sel;
    m1_gnt = hs & sel;
    m0_rvalid = pop & ~head;
    m1_rvalid = pop & head;
    m0_err = s_err & m0_rvalid;
    m1_err = s_err & m1_rvalid;
    m0_rdata = (~empty & ~head) ? s_rdata : '0;
    m1_rdata = (~empty & head) ? s_rdata : '0;
    busy = ~empty;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      owner <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      lock <= 1'b0;
      locked_id <= 1'b0;
      rr_ptr <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (hs) begin
        owner[wp] <= sel;
        wp <= (wp == PW'(MAX_OUT - 1)) ? '0 : wp + 1'b1;
        rr_ptr <= ~sel;
      end
      if (pop) rp <= (rp == PW'(MAX_OUT - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(hs) - CW'(pop);
      // A request left waiting keeps the address phase until its handshake.
      if (hs) lock <= 1'b0;
      else if (s_req) begin
        lock <= 1'b1;
        locked_id <= sel;
      end
      if (s_rvalid & empty) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: randomized scoreboard bench; a transaction-level model predicts grants,
// slave-port drive and response owners, and a monitor checks every forwarded response.
module tb_dbus_arbiter;
  localparam int MAX_OUT = 2;
  typedef struct {int id; logic [31:0] rd; logic er;} resp_t;
  logic Clk = 0, Rst = 1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0] m0_be = 0, m1_be = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_req, s_we;
  logic [3:0] s_be;
  logic [31:0] s_addr, s_wdata;
  logic s_gnt = 0, s_rvalid = 0, s_err = 0;
  logic [31:0] s_rdata = 0;
  logic busy, proto_err;
  int checks = 0, errors = 0;
  resp_t exp_q[$], sq[$];
  int owners[$];
  int waiting = -1, pref = 0;
  bit perr = 0, pend0 = 0, pend1 = 0;

  dbus_arbiter #(.AW(32), .DW(32), .MAX_OUT(MAX_OUT)) dut (
    .Clk(Clk), .Rst(Rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic reset_dut(input bit keep_slave);
    @(negedge Clk);
    Rst = 1; m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
    @(posedge Clk);
    owners.delete(); exp_q.delete();
    if (!keep_slave) sq.delete();
    waiting = -1; pref = 0; perr = 0; pend0 = 0; pend1 = 0;
    @(negedge Clk);
    Rst = 0;
  endtask

  // One bus cycle: present stimulus, compare against the model, then advance the model.
  task automatic step(input bit w0, input bit w1, input bit sg, input bit rv);
    int cand;
    bit esreq, hs, full;
    resp_t r;
    logic [68:0] ef;
    @(negedge Clk);
    if (!pend0 && w0) begin
      pend0 = 1; m0_we = $urandom; m0_be = $urandom; m0_addr = $urandom; m0_wdata = $urandom;
    end
    if (!pend1 && w1) begin
      pend1 = 1; m1_we = $urandom; m1_be = $urandom; m1_addr = $urandom; m1_wdata = $urandom;
    end
    m0_req = pend0; m1_req = pend1;
    s_gnt = sg; s_rvalid = rv;
    if (rv && sq.size() > 0) begin
      s_rdata = sq[0].rd; s_err = sq[0].er;
    end else begin
      s_rdata = $urandom; s_err = $urandom;
    end
    #1;
    cand = waiting >= 0 ? waiting : (pend0 && pend1) ? pref : pend0 ? 0 : pend1 ? 1 : -1;
    full = owners.size() == MAX_OUT;
    esreq = cand >= 0 && !full;
    hs = esreq && sg;
    ef = cand == 0 ? {m0_we, m0_be, m0_addr, m0_wdata} : cand == 1 ? {m1_we, m1_be, m1_addr, m1_wdata} : '0;
    chk("s_req", s_req, esreq);
    chk("s_fields", {s_we, s_be, s_addr, s_wdata}, ef);
    chk("gnt", {m1_gnt, m0_gnt}, {hs && cand == 1, hs && cand == 0});
    chk("busy", busy, owners.size() != 0);
    chk("proto_err", proto_err, perr);
    chk("rvalid_any", m0_rvalid | m1_rvalid, rv && owners.size() != 0);
    chk("rdata_route", {m1_rdata, m0_rdata},
        {(owners.size() != 0 && owners[0] == 1) ? s_rdata : 32'h0,
         (owners.size() != 0 && owners[0] == 0) ? s_rdata : 32'h0});
    @(posedge Clk);
    if (rv) begin
      if (owners.size() != 0) void'(owners.pop_front());
      else perr = 1;
      if (sq.size() > 0) void'(sq.pop_front());
    end
    if (hs) begin
      r.id = cand; r.rd = $urandom; r.er = ($urandom_range(3) == 0);
      owners.push_back(cand); exp_q.push_back(r); sq.push_back(r);
      pref = 1 - cand;
      waiting = -1;
      if (cand == 0) pend0 = 0; else pend1 = 0;
    end else if (esreq) waiting = cand;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sq.size() > 0; i++) step(0, 0, 0, 1);
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (m0_rvalid || m1_rvalid) begin
        if (exp_q.size() == 0) chk("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        else begin
          e = exp_q.pop_front();
          chk("resp_owner", {m1_rvalid, m0_rvalid}, e.id == 1 ? 2'b10 : 2'b01);
          chk("resp_rdata", e.id == 1 ? m1_rdata : m0_rdata, e.rd);
          chk("resp_err", {m1_err, m0_err}, e.id == 1 ? {e.er, 1'b0} : {1'b0, e.er});
        end
      end
    end
  end

  initial begin
    reset_dut(0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, sq.size() > 0);
    drain();
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    drain();
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    drain();
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    reset_dut(1);
    step(1, 1, 0, 1);
    sq.delete();
    step(1, 1, 1, 0);
    step(0, 0, 1, 0);
    drain();
    reset_dut(0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(400) == 0) reset_dut(0);
      step($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(2) != 0,
           sq.size() > 0 ? $urandom_range(1) == 1 : $urandom_range(60) == 0);
    end
    drain();
    step(0, 0, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
